// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// 8N1 UART transmitter fed by a small byte FIFO; one bit per uartEn strobe.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     sysClk,
  input  logic                     reset,
  input  logic                     uartEn,
  input  logic [7:0]               inData,
  input  logic                     inValid,
  output logic                     inReady,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifoCount
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_C = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = (FIFO_DEPTH_LOG2)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 shift_q, shift_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic                       tx_q, tx_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]                 mem_q [DEPTH];
  logic                       push, pop, fifo_nempty;

  assign inReady     = (count_q < DEPTH_C);
  assign fifo_nempty = (count_q != '0);
  assign push        = inValid && inReady;
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE) || fifo_nempty;
  assign fifoCount   = count_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (uartEn) begin
      unique case (state_q)
        S_IDLE, S_STOP: begin
          // Back-to-back frames: a non-empty FIFO at stop goes straight to start.
          if (fifo_nempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_START: begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          if (bit_idx_q != 3'd7) begin
            tx_d      = shift_q[bit_idx_q + 3'd1];
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
`endif
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge sysClk) begin
    if (push) mem_q[wr_ptr_q] <= inData;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: frame vectors from a table plus FIFO/reset corner sequences.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       sysClk = 1'b0;
  logic       reset = 1'b1;
  logic       uartEn = 1'b0;
  logic [7:0] inData = 8'h00;
  logic       inValid = 1'b0;
  logic       inReady, tx, busy;
  logic [2:0] fifoCount;

  int tests = 0;
  int failed = 0;
  int en_period = 0;
  logic man_en = 1'b0;
  int div_cnt = 0;
  bit hold_chk = 1'b0;
  int hold_viol = 0;
  logic tx_prev = 1'b1;
  logic bits_q[$];

  uart_tx_fifo #(.FIFO_DEPTH_LOG2(2)) dut (
    .sysClk(sysClk), .reset(reset), .uartEn(uartEn), .inData(inData),
    .inValid(inValid), .inReady(inReady), .tx(tx), .busy(busy), .fifoCount(fifoCount)
  );

  always #5 sysClk = ~sysClk;

  // Baud strobe: manual when en_period<=0, else one pulse every en_period clocks.
  always @(negedge sysClk) begin
    if (en_period <= 0) begin
      uartEn = man_en;
      div_cnt = 0;
    end else if (div_cnt >= en_period - 1) begin
      uartEn = 1'b1;
      div_cnt = 0;
    end else begin
      uartEn = 1'b0;
      div_cnt++;
    end
  end

  // Record tx launched at every strobe edge; tx must not move on other edges.
  always @(posedge sysClk) begin
    logic en_s;
    en_s = uartEn;
    #1;
    if (en_s) bits_q.push_back(tx);
    else if (hold_chk && (tx !== tx_prev)) hold_viol++;
    tx_prev = tx;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    int         period;
    logic [9:0] bits;
    logic       par;
  } vec_t;
  vec_t tv[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic tick_en(output bit hit);
    @(posedge sysClk);
    hit = uartEn;
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    inData = b;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic wait_en_edges(input string name, input int n, input int budget);
    int seen;
    int k;
    bit hit;
    seen = 0;
    k = 0;
    while (seen < n && k < budget) begin
      tick_en(hit);
      if (hit) seen++;
      k++;
    end
    check(name, 64'(seen), 64'(n));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(busy), 64'(0));
  endtask

  // Bits of nb from the first start bit in the capture; trail counts later zeros.
  task automatic extract(input int nb, output logic [63:0] v, output int trail);
    int first;
    first = -1;
    trail = 0;
    v = 'x;
    for (int i = 0; i < bits_q.size(); i++)
      if (first < 0 && bits_q[i] === 1'b0) first = i;
    if (first >= 0 && first + nb <= bits_q.size()) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = {v[62:0], bits_q[first + i]};
      for (int i = first + nb; i < bits_q.size(); i++)
        if (bits_q[i] !== 1'b1) trail++;
    end
  endtask

  function automatic logic [63:0] full_exp(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return 64'({v.bits[9:1], v.par, 1'b1});
`else
    return 64'(v.bits);
`endif
  endfunction

  function automatic logic [63:0] model(input logic [7:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[62:0], b[i]};
`ifdef UART_TX_PARITY_EN
    r = {r[62:0], ^b};
`endif
    r = {r[62:0], 1'b1};
    return r;
  endfunction

  initial begin
    logic [63:0] got;
    logic [63:0] exp;
    int trail;
    bit hit;

    tv[0] = '{8'h2B, 10, 10'b0110101001, 1'b0};
    tv[1] = '{8'h2E,  1, 10'b0011101001, 1'b0};
    tv[2] = '{8'h2B,  1, 10'b0110101001, 1'b0};
    tv[3] = '{8'h5B,  3, 10'b0110110101, 1'b1};
    tv[4] = '{8'h00,  2, 10'b0000000001, 1'b0};
    tv[5] = '{8'hFF,  4, 10'b0111111111, 1'b0};
    tv[6] = '{8'h80,  1, 10'b0000000011, 1'b1};

    repeat (3) tick();
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(inReady), 64'(1));
    check("rst_count", 64'(fifoCount), 64'(0));
    reset = 1'b0;
    tick();
    hold_chk = 1'b1;

    // Single frames at several baud periods.
    for (int i = 0; i < 7; i++) begin
      en_period = tv[i].period;
      tick();
      bits_q.delete();
      push_byte(tv[i].data);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(1));
      check($sformatf("v%0d_count", i), 64'(fifoCount), 64'(1));
      wait_idle($sformatf("v%0d_idle", i), (FL + 3) * tv[i].period + 10);
      extract(FL, got, trail);
      check($sformatf("v%0d_frame", i), got, full_exp(tv[i]));
      check($sformatf("v%0d_trail", i), 64'(trail), 64'(0));
      check($sformatf("v%0d_txidle", i), 64'(tx), 64'(1));
    end

    // Two frames back-to-back, no idle bit between.
    en_period = 10;
    bits_q.delete();
    push_byte(8'h5B);
    push_byte(8'h2E);
    wait_idle("b2b_idle", 2 * FL * 10 + 50);
    extract(2 * FL, got, trail);
    exp = (full_exp(tv[3]) << FL) | full_exp(tv[1]);
    check("b2b_frames", got, exp);
    check("b2b_trail", 64'(trail), 64'(0));

    // Fill past capacity with no strobe, then one pop.
    en_period = 0;
    man_en = 1'b0;
    repeat (2) tick();
    inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inData = 8'(8'h11 * (i + 1));
      tick();
      check($sformatf("fill%0d_count", i), 64'(fifoCount), 64'((i < 4) ? i + 1 : 4));
      check($sformatf("fill%0d_ready", i), 64'(inReady), 64'((i < 3) ? 1 : 0));
    end
    inValid = 1'b0;
    bits_q.delete();
    en_period = 10;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) tick_en(hit);
    check("fill_pop_seen", 64'(hit), 64'(1));
    check("fill_pop_count", 64'(fifoCount), 64'(3));
    check("fill_pop_ready", 64'(inReady), 64'(1));
    wait_idle("fill_idle", 4 * FL * 10 + 50);
    extract(4 * FL, got, trail);
    exp = (model(8'h11) << (3 * FL)) | (model(8'h22) << (2 * FL)) |
          (model(8'h33) << FL) | model(8'h44);
    check("fill_frames", got, exp);
    check("fill_trail", 64'(trail), 64'(0));

    // Push and pop on the same edge with two bytes queued.
    en_period = 0;
    man_en = 1'b0;
    repeat (2) tick();
    push_byte(8'h3C);
    push_byte(8'hC3);
    check("pp_pre_count", 64'(fifoCount), 64'(2));
    bits_q.delete();
    inData = 8'h96;
    inValid = 1'b1;
    man_en = 1'b1;
    tick();
    inValid = 1'b0;
    man_en = 1'b0;
    check("pp_count", 64'(fifoCount), 64'(2));
    check("pp_tx_start", 64'(tx), 64'(0));
    en_period = 2;
    wait_idle("pp_idle", 3 * FL * 2 + 40);
    extract(3 * FL, got, trail);
    exp = (model(8'h3C) << (2 * FL)) | (model(8'hC3) << FL) | model(8'h96);
    check("pp_frames", got, exp);

    // Asynchronous reset in the middle of data bit 3.
    en_period = 0;
    man_en = 1'b0;
    repeat (2) tick();
    push_byte(8'hA5);
    push_byte(8'h5A);
    en_period = 10;
    wait_en_edges("rst_mid_edges", 5, 80);
    check("rst_mid_bit3", 64'(tx), 64'(0));
    check("rst_mid_count", 64'(fifoCount), 64'(1));
    repeat (3) tick();
    hold_chk = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_tx", 64'(tx), 64'(1));
    check("rst_async_count", 64'(fifoCount), 64'(0));
    check("rst_async_busy", 64'(busy), 64'(0));
    check("rst_async_ready", 64'(inReady), 64'(1));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    hold_chk = 1'b1;
    bits_q.delete();
    push_byte(8'h2B);
    wait_idle("rst_after_idle", (FL + 3) * 10 + 10);
    extract(FL, got, trail);
    check("rst_after_frame", got, full_exp(tv[0]));
    check("rst_after_trail", 64'(trail), 64'(0));

    check("hold_stable", 64'(hold_viol), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
